mc_ctrl_fsm: RTL and testbench

//  Parametrised multicycle MIPS control unit with a memory ready/wait handshake, a wait timeout and a retired-instruction counter.

---
 rtl/mc_ctrl_fsm.sv | 237 +++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control unit with memory ready/wait handshake, wait timeout and retired-instruction counter.
// Optional illegal-opcode trap (TRAP -> TVEC) is built when ILLEGAL_OP_TRAP_EN is defined; otherwise undefined opcodes are NOPs.
module mc_ctrl_fsm #(
    parameter int WAIT_MAX = 15,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        opcode,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              iord,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              branch_ne,
    output logic [1:0]        pc_source,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              ext_zero,
    output logic [2:0]        alu_op,
    output logic              aluout_we,
    output logic              reg_write,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic              illegal_op,
    output logic              epc_write,
    output logic              mem_err,
    output logic [PERF_W-1:0] instret
);
    localparam int            CW    = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] W_MAX = CW'(WAIT_MAX);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_SLTI = 6'h0A;

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MADR, S_MRD, S_MWB, S_MWR, S_EXR, S_RWB,
        S_EXI, S_IWB, S_BR, S_JMP, S_JAL, S_TRAP, S_TVEC, S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_wait_cnt;
    logic                r_mem_err;
    logic                r_br_ne;
    logic [PERF_W-1:0]   r_instret;
    logic                w_retire;
    logic                w_waiting;
    logic                w_timeout;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MRD) || (r_state == S_MWR);
    assign w_timeout = w_waiting && (WAIT_MAX != 0) && (r_wait_cnt == W_MAX) && !mem_ready;
    assign mem_err   = r_mem_err;
    assign instret   = r_instret;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Wait counter: cleared on any state change, counts stalled cycles inside a wait state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_wait_cnt <= '0;
        else if (w_next != r_state)      r_wait_cnt <= '0;
        else if (w_waiting && !mem_ready) r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    // Sticky memory-timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_mem_err <= 1'b0;
        else if (w_timeout) r_mem_err <= 1'b1;
    end

    // Branch polarity captured in DECODE so BR does not need to look at the IR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_br_ne <= 1'b0;
        else if (r_state == S_DECODE) r_br_ne <= opcode[0];
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + 1'b1;
    end

    // Next-state selection and Moore decode; only fetch strobes look at mem_ready
    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ext_zero      = 1'b0;
        alu_op        = 3'b000;
        aluout_we     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        illegal_op    = 1'b0;
        epc_write     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                w_next    = mem_ready ? S_DECODE : (w_timeout ? S_HALT : S_FETCH);
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                aluout_we = 1'b1;
                case (opcode)
                    OP_R:                             w_next = S_EXR;
                    OP_LW, OP_SW:                     w_next = S_MADR;
                    OP_BEQ, OP_BNE:                   w_next = S_BR;
                    OP_J:                             w_next = S_JMP;
                    OP_JAL:                           w_next = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_EXI;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:                          w_next = S_TRAP;
`else
                    default:                          w_next = S_FETCH;
`endif
                endcase
            end
            S_MADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                aluout_we = 1'b1;
                w_next    = (opcode == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                w_next  = mem_ready ? S_MWB : (w_timeout ? S_HALT : S_MRD);
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_MWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                iord     = 1'b1;
                w_next   = mem_ready ? S_FETCH : (w_timeout ? S_HALT : S_MWR);
                w_retire = mem_ready;
            end
            S_EXR: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                aluout_we = 1'b1;
                w_next    = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_EXI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                aluout_we = 1'b1;
                alu_op    = (opcode == OP_ANDI) ? 3'b011 :
                            (opcode == OP_ORI)  ? 3'b100 :
                            (opcode == OP_SLTI) ? 3'b101 : 3'b000;
                ext_zero  = (opcode == OP_ANDI) || (opcode == OP_ORI);
                w_next    = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_BR: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = r_br_ne;
                w_next        = S_FETCH;
                w_retire      = 1'b1;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                illegal_op = 1'b1;
                epc_write  = 1'b1;
                w_next     = S_TVEC;
            end
            S_TVEC: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                w_next    = S_FETCH;
            end
`endif
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized instruction stream checked cycle by cycle against a per-instruction control trace model.
module tb_mc_ctrl_fsm;
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_op;
        logic       aluout_we;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal_op;
        logic       epc_write;
        logic       mem_err;
    } cw_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
    logic       alu_src_a, ext_zero, aluout_we, reg_write, illegal_op, epc_write, mem_err;
    logic [2:0] alu_op;
    logic [7:0] instret;
    cw_t        obs;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_ins = 0;
    int         cyc = 0;
    logic       q_rdy [$];
    logic [5:0] q_op [$];
    cw_t        q_exp [$];
    logic [7:0] q_ins [$];
    logic [5:0] ops [15] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08,
                             6'h0C, 6'h0D, 6'h0A, 6'h3F, 6'h01, 6'h10, 6'h24};

    mc_ctrl_fsm #(.WAIT_MAX(4), .PERF_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_zero(ext_zero), .alu_op(alu_op), .aluout_we(aluout_we), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
        .epc_write(epc_write), .mem_err(mem_err), .instret(instret)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne, pc_source,
                  alu_src_a, alu_src_b, ext_zero, alu_op, aluout_we, reg_write, reg_dst,
                  mem_to_reg, illegal_op, epc_write, mem_err};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic void push(input logic r, input logic [5:0] op, input cw_t c);
        q_rdy.push_back(r);
        q_op.push_back(op);
        q_exp.push_back(c);
        q_ins.push_back(8'(m_ins));
    endfunction

    // Expected per-cycle trace of one instruction: kf fetch stalls, km memory stalls
    task automatic gen_instr(input logic [5:0] op, input int kf, input int km);
        cw_t c;
        c = '0; c.mem_req = 1'b1; c.alu_src_b = 2'b01;
        repeat (kf) push(1'b0, op, c);
        c.ir_write = 1'b1; c.pc_write = 1'b1;
        push(1'b1, op, c);
        c = '0; c.alu_src_b = 2'b11; c.aluout_we = 1'b1;
        push(rnd(), op, c);
        c = '0;
        case (op)
            6'h00: begin
                c.alu_src_a = 1'b1; c.alu_op = 3'b010; c.aluout_we = 1'b1;
                push(rnd(), op, c);
                c = '0; c.reg_dst = 2'b01; c.reg_write = 1'b1;
                push(rnd(), op, c);
                m_ins++;
            end
            6'h23, 6'h2B: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.aluout_we = 1'b1;
                push(rnd(), op, c);
                c = '0; c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = (op == 6'h2B);
                repeat (km) push(1'b0, op, c);
                push(1'b1, op, c);
                if (op == 6'h23) begin
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'b01;
                    push(rnd(), op, c);
                end
                m_ins++;
            end
            6'h04, 6'h05: begin
                c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; c.branch_ne = (op == 6'h05);
                push(rnd(), op, c);
                m_ins++;
            end
            6'h02: begin
                c.pc_write = 1'b1; c.pc_source = 2'b10;
                push(rnd(), op, c);
                m_ins++;
            end
            6'h03: begin
                c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
                c.pc_write = 1'b1; c.pc_source = 2'b10;
                push(rnd(), op, c);
                m_ins++;
            end
            6'h08, 6'h0C, 6'h0D, 6'h0A: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.aluout_we = 1'b1;
                c.alu_op = (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b100 :
                           (op == 6'h0A) ? 3'b101 : 3'b000;
                c.ext_zero = (op == 6'h0C) || (op == 6'h0D);
                push(rnd(), op, c);
                c = '0; c.reg_write = 1'b1;
                push(rnd(), op, c);
                m_ins++;
            end
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                c.illegal_op = 1'b1; c.epc_write = 1'b1;
                push(rnd(), op, c);
                c = '0; c.pc_write = 1'b1; c.pc_source = 2'b11;
                push(rnd(), op, c);
`endif
            end
        endcase
    endtask

    // Drain the expected trace, one cycle per entry, sampling mid-low-phase
    task automatic run_queue();
        cw_t        e;
        logic [7:0] ei;
        while (q_exp.size() > 0) begin
            mem_ready = q_rdy.pop_front();
            opcode = q_op.pop_front();
            e = q_exp.pop_front();
            ei = q_ins.pop_front();
            #1;
            check_eq($sformatf("cw@%0d", cyc), 32'(obs), 32'(e));
            check_eq($sformatf("instret@%0d", cyc), 32'(instret), 32'(ei));
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m_ins = 0;
        push(rnd(), 6'h00, '0);
    endtask

    initial begin
        cw_t c;
        repeat (2) @(negedge clk);
        check_eq("reset_cw", 32'(obs), 32'h0);
        check_eq("reset_instret", 32'(instret), 32'h0);
        release_reset();
        gen_instr(6'h00, 0, 0);
        gen_instr(6'h23, 0, 3);
        gen_instr(6'h05, 0, 0);
        gen_instr(6'h03, 0, 0);
        gen_instr(6'h3F, 0, 0);
        for (int i = 0; i < 300; i++)
            gen_instr(ops[$urandom_range(0, 14)], $urandom_range(0, 4), $urandom_range(0, 4));
        run_queue();

        // sw stalled in MWR, then reset asserted asynchronously
        gen_instr(6'h00, 1, 0);
        c = '0; c.mem_req = 1'b1; c.alu_src_b = 2'b01;
        push(1'b0, 6'h2B, c);
        c.ir_write = 1'b1; c.pc_write = 1'b1;
        push(1'b1, 6'h2B, c);
        c = '0; c.alu_src_b = 2'b11; c.aluout_we = 1'b1;
        push(1'b1, 6'h2B, c);
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.aluout_we = 1'b1;
        push(1'b1, 6'h2B, c);
        c = '0; c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1;
        push(1'b0, 6'h2B, c);
        run_queue();
        mem_ready = 1'b0;
        #1;
        check_eq("mwr_hold", 32'(obs), 32'(c));
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_cw", 32'(obs), 32'h0);
        check_eq("async_rst_instret", 32'(instret), 32'h0);

        // restart through IDLE, then starve FETCH into the timeout
        release_reset();
        gen_instr(6'h0D, 4, 0);
        gen_instr(6'h2B, 0, 4);
        c = '0; c.mem_req = 1'b1; c.alu_src_b = 2'b01;
        repeat (5) push(1'b0, 6'h00, c);
        c = '0; c.mem_err = 1'b1;
        repeat (4) push(rnd(), 6'h00, c);
        run_queue();
        rst_n = 1'b0;
        #1;
        check_eq("halt_rst_cw", 32'(obs), 32'h0);
        check_eq("halt_rst_instret", 32'(instret), 32'h0);
        release_reset();
        gen_instr(6'h00, 0, 0);
        gen_instr(6'h04, 2, 0);
        run_queue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
